spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 10 +
 rtl/sync2.sv | 24 ++
 rtl/spi_slave.sv | 120 ++++++++++++
 tb/tb_spi_slave.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI slave state type and frame constants
package spi_pkg;
    localparam int SPI_FRAME_BITS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_slave_state_t;
endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with configurable reset value
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled 16-bit SPI slave (mode 0 style framing)
// Optional SPI_SLAVE_FRAME_ERR_EN adds frame_err pulse on aborted frames.
module spi_slave
    import spi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [15:0] tx_data,
    input  logic        tx_load,
    output logic [15:0] rx_data,
    output logic        rdy,
    output logic        busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic        frame_err
`endif
);
    logic w_sclk_s, w_ss_s, w_mosi_s;
    logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;

    logic             r_sclk_d, r_ss_d;
    logic [1:0]       r_settle;
    logic             r_armed;
    spi_slave_state_t r_state;
    logic [15:0]      r_tx_buf, r_tx_sr, r_rx_sr, r_rx_data;
    logic [4:0]       r_bit_cnt;
    logic             r_rdy, r_busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic             r_frame_err;
`endif

    sync2 #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .i_d(SCLK), .o_q(w_sclk_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_ss   (.clk(clk), .rst(rst), .i_d(SS_n), .o_q(w_ss_s));
    sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .i_d(MOSI), .o_q(w_mosi_s));

    // After reset the synchronizers hold reset values, not the pin; a frame may
    // only start once SS_n has really been seen high, so a reset inside a frame
    // cannot fabricate a falling edge.
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_ss_fall   = r_armed & r_ss_d & ~w_ss_s;
    assign w_ss_rise   = w_ss_s & ~r_ss_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_d  <= 1'b0;
            r_ss_d    <= 1'b1;
            r_settle  <= 2'd0;
            r_armed   <= 1'b0;
            r_state   <= IDLE;
            r_tx_buf  <= 16'h0000;
            r_tx_sr   <= 16'h0000;
            r_rx_sr   <= 16'h0000;
            r_rx_data <= 16'h0000;
            r_bit_cnt <= 5'd0;
            r_rdy     <= 1'b0;
            r_busy    <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            r_frame_err <= 1'b0;
`endif
        end else begin
            r_sclk_d <= w_sclk_s;
            r_ss_d   <= w_ss_s;
            if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
            else if (w_ss_s)      r_armed  <= 1'b1;
            r_rdy <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            r_frame_err <= 1'b0;
`endif
            if (tx_load) r_tx_buf <= tx_data;

            case (r_state)
                IDLE: begin
                    if (w_ss_fall) begin
                        r_state   <= SHIFT;
                        r_busy    <= 1'b1;
                        r_tx_sr   <= tx_load ? tx_data : r_tx_buf;
                        r_rx_sr   <= 16'h0000;
                        r_bit_cnt <= 5'd0;
                    end
                end
                SHIFT: begin
                    if (w_ss_rise) begin
                        r_busy <= 1'b0;
                        if (r_bit_cnt == 5'(SPI_FRAME_BITS)) begin
                            r_state   <= DONE;
                            r_rx_data <= r_rx_sr;
                            r_rdy     <= 1'b1;
                        end else begin
                            r_state <= IDLE;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                            r_frame_err <= 1'b1;
`endif
                        end
                    end else begin
                        if (w_sclk_rise) begin
                            r_rx_sr <= {r_rx_sr[14:0], w_mosi_s};
                            if (r_bit_cnt != 5'(SPI_FRAME_BITS)) r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                        if (w_sclk_fall) r_tx_sr <= {r_tx_sr[14:0], 1'b0};
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign MISO    = r_busy & r_tx_sr[15];
    assign rx_data = r_rx_data;
    assign rdy     = r_rdy;
    assign busy    = r_busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign frame_err = r_frame_err;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - scoreboard testbench for spi_slave
module tb_spi_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SCLK = 1'b0;
    logic        SS_n = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic [15:0] tx_data = 16'h0000;
    logic        tx_load = 1'b0;
    logic [15:0] rx_data;
    logic        rdy;
    logic        busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic        frame_err;
    int          n_ferr = 0;
`endif

    int n_total = 0;
    int n_bad   = 0;
    logic [15:0] q_miso[$];
    logic [15:0] q_rx[$];
    logic [15:0] miso_w;

    always #5 clk = ~clk;

    spi_slave dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data), .rdy(rdy), .busy(busy)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , .frame_err(frame_err)
`endif
    );

`ifdef SPI_SLAVE_FRAME_ERR_EN
    always @(posedge clk) if (!rst && frame_err) n_ferr++;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load_now(input logic [15:0] v);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    // Master changes MOSI while SCLK is low and samples MISO at SCLK fall.
    task automatic spi_pulse(input logic mosi_b, input logic do_load, output logic miso_b);
        MOSI = mosi_b;
        repeat (16) @(negedge clk);
        SCLK = 1'b1;
        for (int j = 0; j < 16; j++) begin
            tx_load = do_load && (j == 0);
            @(negedge clk);
        end
        tx_load = 1'b0;
        miso_b = MISO;
        SCLK = 1'b0;
    endtask

    task automatic ss_low(input logic load_at_fall);
        SS_n = 1'b0;
        for (int j = 0; j < 16; j++) begin
            tx_load = load_at_fall && (j == 2);
            @(negedge clk);
        end
        tx_load = 1'b0;
        check("busy_in_frame", busy, 1'b1);
    endtask

    // load_mode: 0 none, 1 tx_load coincident with detected SS_n fall, 2 tx_load mid-frame
    task automatic spi_frame(input logic [15:0] mosi_v, input int npulses,
                             input int load_mode, input logic [15:0] ld_val,
                             output logic [15:0] got);
        logic b;
        got = 16'h0000;
        if (load_mode != 0) tx_data = ld_val;
        ss_low(load_mode == 1);
        for (int i = 0; i < npulses; i++) begin
            spi_pulse(mosi_v[15 - i], (load_mode == 2) && (i == 4), b);
            got[15 - i] = b;
        end
        repeat (16) @(negedge clk);
        SS_n = 1'b1;
    endtask

    task automatic wait_rdy(input logic expect_rdy);
        int seen  = 0;
        int first = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rdy) begin
                seen++;
                if (first < 0) first = c;
                if (q_rx.size() > 0) check("rx_data", rx_data, q_rx.pop_front());
            end
            if (c == 6) check("miso_idle", MISO, 1'b0);
        end
        if (expect_rdy) begin
            check("rdy_pulses", seen, 1);
            check("rdy_latency_ok", (first >= 0 && first <= 3), 1'b1);
            if (seen == 0 && q_rx.size() > 0) void'(q_rx.pop_front());
        end else begin
            check("no_rdy", seen, 0);
        end
        check("busy_after", busy, 1'b0);
    endtask

    task automatic full_frame(input logic [15:0] mosi_v, input logic [15:0] exp_miso,
                              input int load_mode, input logic [15:0] ld_val);
        q_miso.push_back(exp_miso);
        q_rx.push_back(mosi_v);
        spi_frame(mosi_v, 16, load_mode, ld_val, miso_w);
        check("miso_word", miso_w, q_miso.pop_front());
        wait_rdy(1'b1);
    endtask

    initial begin
        logic b;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_rx_data", rx_data, 16'h0000);
        check("rst_rdy", rdy, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_miso", MISO, 1'b0);

        load_now(16'hA5C3);
        repeat (4) @(negedge clk);
        full_frame(16'h1234, 16'hA5C3, 0, 16'h0);

        full_frame(16'hFFFF, 16'hA5C3, 0, 16'h0);
        full_frame(16'h0001, 16'hA5C3, 0, 16'h0);

        full_frame(16'h5555, 16'hA5C3, 2, 16'h0F0F);
        full_frame(16'h00AA, 16'h0F0F, 0, 16'h0);

        spi_frame(16'h1357, 9, 0, 16'h0, miso_w);
        check("abort_miso_prefix", miso_w[15:7], 9'(16'h0F0F >> 7));
        wait_rdy(1'b0);
        check("abort_rx_kept", rx_data, 16'h00AA);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("frame_err_count", n_ferr, 1);
`endif

        full_frame(16'h2468, 16'h8001, 1, 16'h8001);

        ss_low(1'b0);
        for (int i = 0; i < 8; i++) spi_pulse(1'b1, 1'b0, b);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rx_data", rx_data, 16'h0000);
        check("midrst_busy", busy, 1'b0);
        for (int i = 0; i < 8; i++) spi_pulse(1'b0, 1'b0, b);
        check("midrst_tail_miso", MISO, 1'b0);
        repeat (16) @(negedge clk);
        SS_n = 1'b1;
        wait_rdy(1'b0);
        check("midrst_rx_still0", rx_data, 16'h0000);

        full_frame(16'hBEEF, 16'h0000, 0, 16'h0);
        check("final_rx", rx_data, 16'hBEEF);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("frame_err_total", n_ferr, 1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
